// File: rtl/i2c_target_regs.sv
// I2C target with a byte-addressed register file. SCL/SDA are oversampled
// on aclk; SDA is answered open-drain through sda_oe.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         DEPTH       = 16,
  localparam int        PW          = $clog2(DEPTH)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          scl,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_valid,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } state_t;

  state_t        state_reg, state_next;
  logic [2:0]    scl_sync_reg, sda_sync_reg;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic          sda_oe_reg, sda_oe_next;
  logic          wr_valid_reg, wr_valid_next;
  logic [PW-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]    wr_data_reg, wr_data_next;
  logic [7:0]    rd_data_reg;
  logic [7:0]    mem [DEPTH];
  logic          mem_we;
  logic [7:0]    rx_byte;
  logic          scl_rise, scl_fall, sda_s, start_det, stop_det;

  // Synchronizers idle high so leaving reset on a quiet bus creates no events.
  always_ff @(posedge aclk) begin
    if (areset) begin
      scl_sync_reg <= 3'b111;
      sda_sync_reg <= 3'b111;
    end else begin
      scl_sync_reg <= {scl_sync_reg[1:0], scl};
      sda_sync_reg <= {sda_sync_reg[1:0], sda_i};
    end
  end

  assign scl_rise  = scl_sync_reg[1] & ~scl_sync_reg[2];
  assign scl_fall  = ~scl_sync_reg[1] & scl_sync_reg[2];
  assign sda_s     = sda_sync_reg[1];
  assign start_det = scl_sync_reg[1] & scl_sync_reg[2] & sda_sync_reg[2] & ~sda_sync_reg[1];
  assign stop_det  = scl_sync_reg[1] & scl_sync_reg[2] & ~sda_sync_reg[2] & sda_sync_reg[1];
  assign rx_byte   = {shift_reg[6:0], sda_s};

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data_reg <= '0;
    end else begin
      if (mem_we) mem[ptr_reg] <= rx_byte;
      rd_data_reg <= mem[ptr_reg];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      ptr_reg      <= '0;
      sda_oe_reg   <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      ptr_reg      <= ptr_next;
      sda_oe_reg   <= sda_oe_next;
      wr_valid_reg <= wr_valid_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    ptr_next      = ptr_reg;
    sda_oe_next   = sda_oe_reg;
    wr_valid_next = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    mem_we        = 1'b0;
    if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
    end else if (stop_det) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
    end else begin
      case (state_reg)
        ADDR, PTR, WR: begin
          if (scl_rise && bit_cnt_reg < 4'd8) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7 && state_reg == PTR) ptr_next = rx_byte[PW-1:0];
            if (bit_cnt_reg == 4'd7 && state_reg == WR) begin
              mem_we        = 1'b1;
              wr_valid_next = 1'b1;
              wr_addr_next  = ptr_reg;
              wr_data_next  = rx_byte;
              ptr_next      = ptr_reg + PW'(1);
            end
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            // The ACK slot opens at the 8th falling edge.
            bit_cnt_next = '0;
            if (state_reg == ADDR && shift_reg[7:1] != TARGET_ADDR) begin
              state_next = IGNORE;
            end else begin
              sda_oe_next = 1'b1;
              state_next  = (state_reg == ADDR) ? ADDR_ACK :
                            (state_reg == PTR)  ? PTR_ACK  : WR_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_next = '0;
            if (shift_reg[0]) begin
              shift_next  = rd_data_reg;
              sda_oe_next = ~rd_data_reg[7];
              ptr_next    = ptr_reg + PW'(1);
              state_next  = RD;
            end else begin
              sda_oe_next = 1'b0;
              state_next  = PTR;
            end
          end
        end
        PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
            state_next  = WR;
          end
        end
        RD: begin
          if (scl_fall) begin
            shift_next   = {shift_reg[6:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = '0;
              state_next   = RD_ACK;
            end else begin
              sda_oe_next = ~shift_reg[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_s) begin
            state_next = IGNORE;
          end else if (scl_fall) begin
            shift_next   = rd_data_reg;
            sda_oe_next  = ~rd_data_reg[7];
            ptr_next     = ptr_reg + PW'(1);
            bit_cnt_next = '0;
            state_next   = RD;
          end
        end
        default: sda_oe_next = 1'b0;
      endcase
    end
  end

  assign sda_oe   = sda_oe_reg;
  assign wr_valid = wr_valid_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign busy     = (state_reg != IDLE) && (state_reg != IGNORE);

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master drives the
// bus, write/readback vectors come from a table, corner cases are scripted.
module tb_i2c_target_regs;

  logic       clk, areset, scl_m, sda_m;
  logic       sda_oe, wr_valid, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  wire logic  sda_i = sda_m & ~sda_oe;

  i2c_target_regs #(.TARGET_ADDR(7'h50), .DEPTH(16)) dut (
    .aclk(clk), .areset(areset), .scl(scl_m), .sda_i(sda_i), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int oe_cnt  = 0;
  logic [3:0] wq_addr[$];
  logic [7:0] wq_data[$];

  always @(negedge clk) begin
    if (wr_valid) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sbit(input logic b, output logic r);
    tick(2); sda_m = b; tick(6); scl_m = 1'b1; tick(5); r = sda_i; tick(5); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    tick(2); sda_m = 1'b1; tick(6); scl_m = 1'b1; tick(5); sda_m = 1'b0; tick(5); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(2); sda_m = 1'b0; tick(6); scl_m = 1'b1; tick(5); sda_m = 1'b1; tick(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) sbit(b[i], r);
    sbit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      sbit(1'b1, r);
      d[i] = r;
    end
    sbit(nack, r);
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] d0, d1;
    logic [3:0] a0, a1;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic       ack, r;
    logic [7:0] d0, d1;
    int         oe0;

    vecs[0] = '{ptr: 8'h03, d0: 8'h11, d1: 8'h22, a0: 4'd3,  a1: 4'd4};
    vecs[1] = '{ptr: 8'h0F, d0: 8'hAA, d1: 8'hBB, a0: 4'd15, a1: 4'd0};
    vecs[2] = '{ptr: 8'h07, d0: 8'h5A, d1: 8'hC3, a0: 4'd7,  a1: 4'd8};

    scl_m = 1'b1; sda_m = 1'b1; areset = 1'b1;
    tick(4);
    areset = 1'b0;
    tick(2);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);

    for (int v = 0; v < 3; v++) begin
      wq_addr.delete(); wq_data.delete();
      i2c_start();
      send_byte(8'hA0, ack);       check("wr_addr_ack", ack, 0);
      check("busy_in_xfer", busy, 1);
      send_byte(vecs[v].ptr, ack); check("wr_ptr_ack", ack, 0);
      send_byte(vecs[v].d0, ack);  check("wr_d0_ack", ack, 0);
      send_byte(vecs[v].d1, ack);  check("wr_d1_ack", ack, 0);
      i2c_stop();
      check("wr_pulse_count", wq_addr.size(), 2);
      check("wr_pulse0_addr", (wq_addr.size() > 0) ? wq_addr[0] : 4'hx, vecs[v].a0);
      check("wr_pulse0_data", (wq_data.size() > 0) ? wq_data[0] : 8'hxx, vecs[v].d0);
      check("wr_pulse1_addr", (wq_addr.size() > 1) ? wq_addr[1] : 4'hx, vecs[v].a1);
      check("wr_pulse1_data", (wq_data.size() > 1) ? wq_data[1] : 8'hxx, vecs[v].d1);

      i2c_start();
      send_byte(8'hA0, ack);       check("rb_addr_ack", ack, 0);
      send_byte(vecs[v].ptr, ack); check("rb_ptr_ack", ack, 0);
      i2c_start();
      send_byte(8'hA1, ack);       check("rb_raddr_ack", ack, 0);
      read_byte(1'b0, d0);         check("rb_byte0", d0, vecs[v].d0);
      read_byte(1'b1, d1);         check("rb_byte1", d1, vecs[v].d1);
      check("rb_busy_after_nack", busy, 0);
      check("rb_sda_released", sda_oe, 0);
      i2c_stop();
    end

    // Address mismatch: never drives SDA, never writes.
    wq_addr.delete(); wq_data.delete();
    oe0 = oe_cnt;
    i2c_start();
    send_byte(8'hA2, ack);         check("mis_addr_nack", ack, 1);
    check("mis_busy", busy, 0);
    send_byte(8'h33, ack);         check("mis_data_nack", ack, 1);
    i2c_stop();
    check("mis_oe_cycles", oe_cnt - oe0, 0);
    check("mis_wr_pulses", wq_addr.size(), 0);

    // Pointer-only write, then current-address read.
    i2c_start();
    send_byte(8'hA0, ack);         check("po_addr_ack", ack, 0);
    send_byte(8'h07, ack);         check("po_ptr_ack", ack, 0);
    i2c_stop();
    check("po_wr_pulses", wq_addr.size(), 0);
    i2c_start();
    send_byte(8'hA1, ack);         check("po_raddr_ack", ack, 0);
    read_byte(1'b1, d0);           check("po_read", d0, 8'h5A);
    i2c_stop();

    // Abort after four data bits: no write, pointer untouched.
    i2c_start();
    send_byte(8'hA0, ack);         check("ab_addr_ack", ack, 0);
    send_byte(8'h03, ack);         check("ab_ptr_ack", ack, 0);
    sbit(1'b1, r); sbit(1'b0, r); sbit(1'b1, r); sbit(1'b0, r);
    i2c_stop();
    check("ab_wr_pulses", wq_addr.size(), 0);
    i2c_start();
    send_byte(8'hA1, ack);         check("ab_raddr_ack", ack, 0);
    read_byte(1'b1, d0);           check("ab_old_value", d0, 8'h11);
    i2c_stop();

    // Reset while the target is pulling SDA low during a read.
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h03, ack);
    i2c_start();
    send_byte(8'hA1, ack);         check("rs_raddr_ack", ack, 0);
    tick(6);
    check("rs_oe_before", sda_oe, 1);
    areset = 1'b1;
    @(posedge clk); #1;
    check("rs_oe_after", sda_oe, 0);
    check("rs_busy_after", busy, 0);
    check("rs_wr_addr_after", wr_addr, 0);
    check("rs_wr_data_after", wr_data, 0);
    @(negedge clk);
    areset = 1'b0;
    i2c_stop();
    i2c_start();
    send_byte(8'hA0, ack);         check("rs2_addr_ack", ack, 0);
    send_byte(8'h03, ack);
    i2c_start();
    send_byte(8'hA1, ack);
    read_byte(1'b0, d0);           check("rs2_reg3", d0, 8'h00);
    read_byte(1'b1, d1);           check("rs2_reg4", d1, 8'h00);
    i2c_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) with a byte-addressed register file. It sits on the I2C bus directly downstream of `i2c_axi_lite`, consuming its SCL/SDA and answering with an open-drain SDA. In co-simulation it replaces the behavioural bus model as the synthesizable target. On FPGA it gives on-chip loopback of the I2C master. It oversamples the bus on the system clock and does not use SCL as a clock.

## Interface
Parameters:
- `TARGET_ADDR`, default 7'h50: 7-bit bus address this block answers to.
- `DEPTH`, default 16: register count, power of 2, range 2..256; `PW = $clog2(DEPTH)`.

Ports:
- `aclk`  in  1  system clock; must be ≥ 16× the SCL frequency.
- `areset`  in  1  synchronous, active-high reset.
- `scl`  in  1  bus clock from the master.
- `sda_i`  in  1  resolved bus SDA level.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release (pull-up).
- `wr_valid`  out  1  one-cycle pulse when a register is written.
- `wr_addr`  out  PW  index of the register written.
- `wr_data`  out  8  value written.
- `busy`  out  1  1 from an addressed START until STOP, NACK or address mismatch.

## Operation
- **Input conditioning:** `scl` and `sda_i` each pass through 2-FF synchronizers and then a third registered stage for edge detection.
  - `scl_rise` / `scl_fall`: one-cycle strobes.
  - START: synced SDA falls while synced SCL is 1.
  - STOP: synced SDA rises while synced SCL is 1.
- **Event priority:** START/STOP take precedence over any state. START in any state (repeated start) → ADDR with the bit counter cleared. STOP → IDLE.
- **Data sampling:** SDA is sampled on `scl_rise`, MSB first. `sda_oe` changes only in the cycle after `scl_fall`.
- **States:**
  - IDLE: release SDA, wait for START.
  - ADDR: shift in 8 bits. If addr[7:1]==TARGET_ADDR → ADDR_ACK. Otherwise → IGNORE and do not drive SDA.
  - ADDR_ACK: drive low for the 9th clock. At the closing `scl_fall`, R/W=0 → PTR. R/W=1 → load shifter from `reg[ptr]`, `ptr++`, → RD.
  - PTR: shift in 8 bits; `ptr <= byte[PW-1:0]`; → PTR_ACK.
  - PTR_ACK: ACK, then → WR.
  - WR: shift in 8 bits. At the 8th `scl_rise`, next cycle: `reg[ptr]<=byte`, `wr_valid=1`, `wr_addr=ptr`, `wr_data=byte`, `ptr++`. Then → WR_ACK.
  - WR_ACK: ACK, then → WR.
  - RD: drive `sda_oe = ~shift[7]` after each `scl_fall` and shift left. After the 8th bit's `scl_fall`, release → RD_ACK.
  - RD_ACK: sample master ACK at `scl_rise`. Low: at `scl_fall`, load `reg[ptr]`, `ptr++`, → RD. High (NACK) → IGNORE.
  - IGNORE: release SDA; leave only on START or STOP.
- **Pointer:** `ptr` is PW bits and wraps from DEPTH-1 to 0. `ptr` persists across transactions; it is reset only by `areset`.
- **Write rules:**
  - A write with no data byte (S, addr+W, ptr, P) sets `ptr` only.
  - A partial byte followed by STOP is discarded: no write pulse, no ptr change.

## Timing
- **Reset values:** `sda_oe=0`, `wr_valid=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, state IDLE, `ptr=0`, all registers 8'h00.
- **Latency:**
  - Bus edge to internal strobe: 3 aclk.
  - `sda_oe` update: 1 aclk after `scl_fall`, i.e. 4 aclk after the physical edge.
- **Write visibility:** `wr_valid` is asserted 1 aclk after the 8th data `scl_rise` strobe, for exactly 1 cycle. The register value is readable from the next cycle.
- **ACK hold:** the ACK low is held from the 8th `scl_fall` to the 9th `scl_fall`.
- **STOP during RD/ACK:** SDA is released the cycle after the STOP strobe.
- **Reset mid-transfer:** `areset` during a transfer releases SDA the next cycle and returns all state to reset values. The bus is then ignored until a fresh START.

## Test plan
- **Write burst:** S, 0xA0, ptr 0x03, data 0x11, 0x22, P → ACK on all four bytes. Two `wr_valid` pulses with (3,0x11) then (4,0x22); `reg[3]=0x11`, `reg[4]=0x22`.
- **Pointer wrap:** ptr 0x0F, data 0xAA, 0xBB → writes at 15, then 0 (DEPTH=16).
- **Repeated-start read:** S, 0xA0, 0x03, Sr, 0xA1, read 2 bytes with ACK then NACK, P → returns 0x11, 0x22. SDA released after the NACK; `busy=0`.
- **Address mismatch:** S, 0xA2, … → 9th bit samples high (NACK). `sda_oe` stays 0 and no `wr_valid` pulse until the next START.
- **Abort mid-byte:** 4 data bits then STOP → no write pulse; a subsequent read from the same ptr returns the old value.
- **Reset mid-transfer:** `areset` asserted during RD with `sda_oe=1` → `sda_oe=0` the next cycle and all registers read 0x00 afterwards.
